// File: rtl/ps2_device_tx.sv
// ps2_device_tx: device-side PS/2 transmitter. It queues scan codes in a small
// FIFO and sends each one as an 11-bit frame on a PS/2 clock that it generates
// itself. If the host holds the clock low, the frame is aborted and the head
// byte is sent again once the lines have been idle long enough.
module ps2_device_tx #(
    parameter int HALF_CYC   = 2000,
    parameter int IDLE_CYC   = 2500,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            code_in,
    input  logic                  code_valid,
    output logic                  code_ready,
    output logic                  dropped,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  busy,
    output logic                  ps2_clk_out,
    output logic                  ps2_dat_out,
    input  logic                  ps2_clk_in,
    input  logic                  ps2_dat_in
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int HW    = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int IW    = $clog2(IDLE_CYC + 1);

    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYC - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYC);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [3:0]    LAST_BIT  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_GAP,
        S_ABORT
    } state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         half_cnt_q, half_cnt_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [10:0]           frame_q, frame_d;
    logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            mem_q [DEPTH];

    logic clk_s1_q, clk_s2_q;
    logic dat_s1_q, dat_s2_q;

    logic       push, pop, idle_clr;
    logic       clk_o, dat_o;
    logic [7:0] head;

    assign code_ready  = (count_q != FULL_CNT);
    assign dropped     = code_valid & ~code_ready;
    assign push        = code_valid & code_ready;
    assign fifo_count  = count_q;
    assign busy        = (state_q != S_IDLE);
    assign head        = mem_q[rd_ptr_q];
    assign ps2_clk_out = clk_o;
    assign ps2_dat_out = dat_o;

    // Two-flop synchronisers for the sampled bus lines; they reset to the pulled-up level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_in;
            dat_s2_q <= dat_s1_q;
        end
    end

    // FIFO storage needs no reset: the pointers and the count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= code_in;
    end

    // FIFO bookkeeping. A full FIFO rejects a push even when a pop happens in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Idle counter: consecutive cycles with both lines high. It saturates, and GAP clears it.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (idle_clr || !(clk_s2_q && dat_s2_q))
            idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX)
            idle_cnt_d = idle_cnt_q + 1'b1;
    end

    // Frame FSM. Each bit gets a HIGH half and then a LOW half. The host can inhibit only at the end of a HIGH half.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        pop        = 1'b0;
        idle_clr   = 1'b0;
        clk_o      = 1'b1;
        dat_o      = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && idle_cnt_q == IDLE_MAX) begin
                    // {stop, odd parity, d7..d0, start}; bit 0 goes out first
                    frame_d    = {1'b1, ~^head, head, 1'b0};
                    bit_idx_d  = '0;
                    half_cnt_d = '0;
                    state_d    = S_HIGH;
                end
            end
            S_HIGH: begin
                dat_o = frame_q[bit_idx_q];
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    state_d    = clk_s2_q ? S_LOW : S_ABORT;
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            S_LOW: begin
                clk_o = 1'b0;
                dat_o = frame_q[bit_idx_q];
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        pop     = 1'b1;
                        state_d = S_GAP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        state_d   = S_HIGH;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                idle_clr = 1'b1;
                state_d  = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers. Reset releases the lines and empties the FIFO, which discards any byte in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            half_cnt_q <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '1;
            idle_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            idle_cnt_q <= idle_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: directed bench for ps2_device_tx with HALF_CYC=4, IDLE_CYC=6, DEPTH_LOG2=3.
module tb_ps2_device_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       code_ready, dropped, busy;
    logic [3:0] fifo_count;
    logic       ps2_clk_out, ps2_dat_out;
    logic       ps2_clk_in, ps2_dat_in;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Wired-AND bus with pull-ups: either side can pull a line low.
    assign ps2_clk_in = ps2_clk_out & ~host_clk_low;
    assign ps2_dat_in = ps2_dat_out & ~host_dat_low;

    ps2_device_tx #(.HALF_CYC(4), .IDLE_CYC(6), .DEPTH_LOG2(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .dropped(dropped), .fifo_count(fifo_count),
        .busy(busy), .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture one frame: record the data value at each clock fall and stop at the release after the stop bit.
    task automatic get_frame(output logic [10:0] bits, output int t_start, output int t_fall0,
                             output int t_end, output int per, output logic ok);
        int   nf;
        int   f1;
        logic prev;
        nf = 0; f1 = -1; bits = '0; t_start = -1; t_fall0 = -1; t_end = -1; per = 0; ok = 1'b0;
        prev = ps2_clk_out;
        if (busy && ps2_clk_out && !ps2_dat_out) t_start = cyc;
        for (int i = 0; i < 400; i++) begin
            step();
            if (t_start < 0 && busy && ps2_clk_out && !ps2_dat_out) t_start = cyc;
            if (prev && !ps2_clk_out) begin
                if (nf < 11) bits[nf] = ps2_dat_out;
                if (nf == 0) t_fall0 = cyc;
                if (nf == 1) f1 = cyc;
                nf++;
            end
            if (nf >= 11 && ps2_clk_out) begin
                t_end = cyc;
                ok = 1'b1;
                break;
            end
            prev = ps2_clk_out;
        end
        per = f1 - t_fall0;
    endtask

    task automatic test_reset();
        int act;
        reset_n = 1'b0;
        repeat (3) step();
        total++;
        if ({ps2_clk_out, ps2_dat_out, code_ready, dropped, busy} !== 5'b11100 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_hold: got clk=%b dat=%b rdy=%b drop=%b busy=%b cnt=%0d want 1 1 1 0 0 0",
                     ps2_clk_out, ps2_dat_out, code_ready, dropped, busy, fifo_count);
        end
        reset_n = 1'b1;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!ps2_clk_out || !ps2_dat_out || busy || fifo_count != 0) act++;
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("FAIL reset_quiet: got %0d active cycles want 0", act);
        end
    endtask

    task automatic test_single();
        logic [10:0] bits;
        int ts, tf, te, per;
        logic ok;
        repeat (4) step();
        code_in = 8'h1C; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        total++;
        if (fifo_count !== 4'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_cnt1: got cnt=%0d busy=%b want 1 0", fifo_count, busy);
        end
        step();
        total++;
        if (busy !== 1'b1 || ps2_dat_out !== 1'b0 || ps2_clk_out !== 1'b1) begin
            bad++;
            $display("FAIL single_start: got busy=%b dat=%b clk=%b want 1 0 1", busy, ps2_dat_out, ps2_clk_out);
        end
        get_frame(bits, ts, tf, te, per, ok);
        total++;
        if (ok !== 1'b1 || bits !== 11'b10000111000) begin
            bad++;
            $display("FAIL single_bits: got ok=%b bits=%b want 1 10000111000", ok, bits);
        end
        total++;
        if (tf - ts !== 4 || per !== 8 || te - ts !== 88) begin
            bad++;
            $display("FAIL single_timing: got fall0=%0d period=%0d len=%0d want 4 8 88", tf - ts, per, te - ts);
        end
        total++;
        if (fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL single_pop: got cnt=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_parity();
        logic [10:0] bits;
        int ts, tf, te, per;
        logic ok;
        repeat (12) step();
        code_in = 8'hF0; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        get_frame(bits, ts, tf, te, per, ok);
        total++;
        if (ok !== 1'b1 || bits !== 11'b11111100000) begin
            bad++;
            $display("FAIL parity_f0: got ok=%b bits=%b want 1 11111100000", ok, bits);
        end
        repeat (12) step();
        code_in = 8'h00; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        get_frame(bits, ts, tf, te, per, ok);
        total++;
        if (ok !== 1'b1 || bits !== 11'b11000000000) begin
            bad++;
            $display("FAIL parity_00: got ok=%b bits=%b want 1 11000000000", ok, bits);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_bits [3];
        logic [3:0]  exp_cnt [3];
        logic [10:0] bits;
        int ts, tf, te, per, prev_end;
        logic ok;
        exp_bits[0] = 11'b10111000000;  // 0xE0
        exp_bits[1] = 11'b10011101010;  // 0x75
        exp_bits[2] = 11'b10111000000;  // 0xE0
        exp_cnt[0] = 4'd2; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd0;
        repeat (12) step();
        code_valid = 1'b1;
        code_in = 8'hE0; step();
        code_in = 8'h75; step();
        code_in = 8'hE0; step();
        code_valid = 1'b0;
        total++;
        if (fifo_count !== 4'd3) begin
            bad++;
            $display("FAIL b2b_cnt3: got cnt=%0d want 3", fifo_count);
        end
        prev_end = -1;
        for (int k = 0; k < 3; k++) begin
            get_frame(bits, ts, tf, te, per, ok);
            total++;
            if (ok !== 1'b1 || bits !== exp_bits[k] || fifo_count !== exp_cnt[k]) begin
                bad++;
                $display("FAIL b2b_frame%0d: got ok=%b bits=%b cnt=%0d want 1 %b %0d",
                         k, ok, bits, fifo_count, exp_bits[k], exp_cnt[k]);
            end
            if (k > 0) begin
                total++;
                if (ts - prev_end < 7) begin
                    bad++;
                    $display("FAIL b2b_gap%0d: got spacing=%0d want >=7", k, ts - prev_end);
                end
            end
            prev_end = te;
        end
    endtask

    task automatic test_abort();
        logic [10:0] bits;
        int ts, tf, te, per, rel, falls;
        logic ok;
        repeat (12) step();
        code_in = 8'h5A; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        step();                      // start-bit HIGH begins here
        repeat (32) step();          // HIGH half of bit 4 (d3) begins here
        total++;
        if (ps2_clk_out !== 1'b1 || ps2_dat_out !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_d3: got clk=%b dat=%b busy=%b want 1 1 1", ps2_clk_out, ps2_dat_out, busy);
        end
        host_clk_low = 1'b1;
        falls = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!ps2_clk_out) falls++;
        end
        total++;
        if (falls !== 0 || busy !== 1'b0 || ps2_clk_out !== 1'b1 || ps2_dat_out !== 1'b1 || fifo_count !== 4'd1) begin
            bad++;
            $display("FAIL abort_release: got lowclk=%0d busy=%b clk=%b dat=%b cnt=%0d want 0 0 1 1 1",
                     falls, busy, ps2_clk_out, ps2_dat_out, fifo_count);
        end
        repeat (4) step();
        host_clk_low = 1'b0;
        rel = cyc;
        get_frame(bits, ts, tf, te, per, ok);
        total++;
        if (ok !== 1'b1 || bits !== 11'b11010110100 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL abort_resend: got ok=%b bits=%b cnt=%0d want 1 11010110100 0", ok, bits, fifo_count);
        end
        total++;
        if (ts - rel < 6) begin
            bad++;
            $display("FAIL abort_wait: got start %0d cycles after release want >=6", ts - rel);
        end
    endtask

    task automatic test_overflow();
        int early_drop, starts;
        repeat (4) step();
        host_clk_low = 1'b1;
        repeat (4) step();
        early_drop = 0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            code_in = 8'(8'h10 + i);
            code_valid = 1'b1;
            #1;
            if (dropped) early_drop++;
            step();
            if (busy) starts++;
        end
        total++;
        if (code_ready !== 1'b0 || fifo_count !== 4'd8 || early_drop !== 0) begin
            bad++;
            $display("FAIL ovf_full: got rdy=%b cnt=%0d drops=%0d want 0 8 0", code_ready, fifo_count, early_drop);
        end
        code_in = 8'h99;
        #1;
        total++;
        if (dropped !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drop: got dropped=%b want 1", dropped);
        end
        step();
        code_valid = 1'b0;
        #1;
        repeat (10) begin
            step();
            if (busy) starts++;
        end
        total++;
        if (dropped !== 1'b0 || fifo_count !== 4'd8 || starts !== 0) begin
            bad++;
            $display("FAIL ovf_after: got dropped=%b cnt=%0d starts=%0d want 0 8 0", dropped, fifo_count, starts);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        host_clk_low = 1'b0;
        total++;
        if (fifo_count !== 4'd0 || code_ready !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flush: got cnt=%0d rdy=%b want 0 1", fifo_count, code_ready);
        end
    endtask

    task automatic test_reset_midframe();
        int act;
        repeat (12) step();
        code_in = 8'hA5; code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        repeat (25) step();
        reset_n = 1'b0;
        step();
        total++;
        if (ps2_clk_out !== 1'b1 || ps2_dat_out !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL midreset: got clk=%b dat=%b busy=%b cnt=%0d want 1 1 0 0",
                     ps2_clk_out, ps2_dat_out, busy, fifo_count);
        end
        reset_n = 1'b1;
        act = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy || !ps2_clk_out) act++;
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("FAIL midreset_discard: got %0d active cycles want 0", act);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_abort();
        test_overflow();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
